axistream_unpack: RTL and testbench
===================================

Name: axistream_unpack

Overview:
Splits each wide AXI-Stream word into NUM_PACK narrow elements and emits them one per beat. It is the inverse of the pack stage and sits directly downstream of a wide datapath that feeds a narrow consumer, for example a 32-bit processing core driving an 8-bit link. It buffers one word and sustains full throughput: a new word is accepted on the same cycle its predecessor's final element leaves.

Parameters:
- DATA_WIDTH, 8, width in bits of one output element.
- NUM_PACK, 4, number of elements per input word; must be at least 2.
- BIG_ENDIAN, 1'b0, when 1 the most significant element is emitted first; when 0 the least significant is emitted first.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- src_tvalid  in  1  input word valid.
- src_tready  out  1  input word accepted.
- src_tdata  in  DATA_WIDTH*NUM_PACK  wide input word.
- src_tlast  in  1  input word ends the packet.
- dest_tvalid  out  1  output element valid.
- dest_tready  in  1  downstream ready.
- dest_tdata  out  DATA_WIDTH  output element.
- dest_tlast  out  1  high only on the final emitted element of a src_tlast word.
- src_tkeep  in  NUM_PACK  per-element keep; present only with the optional feature.
- null_last_err  out  1  one-cycle pulse; present only with the optional feature.

Behaviour:
- State: data_buf (one wide word), last_buf (1 bit), idx (element index, $clog2(NUM_PACK) bits), full flag.
- Reset:
  - While rst is high: dest_tvalid=0, src_tready=0, dest_tlast=0, null_last_err=0.
  - On the next edge: full=0 and idx=0.
  - data_buf is not reset.
- Handshakes:
  - dest_tvalid = full && !rst.
  - src_tready = !rst && (!full || (dest_tready && idx is the final element)).
- Latency: one cycle from the src handshake to the first dest_tvalid.
- Element order:
  - Little-endian: element k = data_buf[k*DATA_WIDTH +: DATA_WIDTH], k = 0..NUM_PACK-1.
  - Big-endian: k runs from NUM_PACK-1 down to 0.
- dest_tdata and dest_tlast must hold stable while dest_tvalid && !dest_tready.
- On a dest handshake that is not the final element: idx increments.
- On a dest handshake of the final element:
  - If src_tvalid is also high (it is accepted in the same cycle): load data_buf and last_buf, set idx=0, keep full=1. This is the zero-bubble case.
  - Otherwise set full=0 and idx=0.
- On a src handshake while empty: load the buffers, set full=1, idx=0.
- dest_tlast = last_buf && the final element is being presented.
- Reset mid-word drops the remaining elements. The first word after reset starts at element 0.
- No wrap-around hazard: idx never exceeds NUM_PACK-1.

Optional Feature:
- Macro: AXISTREAM_UNPACK_TKEEP_EN.
- With the macro defined:
  - src_tkeep is latched with each word. Elements whose keep bit is 0 are skipped without spending a beat.
  - The final element is the last kept element in emission order, and dest_tlast marks it.
  - An all-zero keep word is consumed in one cycle with no output.
  - If that all-zero word carries src_tlast, null_last_err pulses for one cycle.
  - The next-kept-element selection is a priority encoder, so throughput stays at one kept element per cycle.
- Without the macro: src_tkeep and null_last_err do not exist, and all NUM_PACK elements are emitted.

Decomposition:
- Shared package axistream_pkg holds:
  - the index-width constant function (clog2 helper);
  - the endianness constants AXIS_LITTLE=1'b0 and AXIS_BIG=1'b1, shared with the pack stage.
- One sub-module, axistream_unpack_sel: combinational element mux plus next-kept-index encoder, parameterised by DATA_WIDTH, NUM_PACK and BIG_ENDIAN.

Test Plan (DATA_WIDTH=8, NUM_PACK=4):
- Little-endian ordering: word 0x44332211 with tlast=1, dest_tready=1 -> dest_tdata 0x11, 0x22, 0x33, 0x44; dest_tlast only on 0x44.
- Big-endian ordering: same word with BIG_ENDIAN=1 -> 0x44, 0x33, 0x22, 0x11; dest_tlast on 0x11.
- Back-to-back throughput: 0xDDCCBBAA then 0x04030201, both streams held ready -> 8 consecutive valid beats with no bubble; src_tready high only on the cycles element 3 handshakes.
- Backpressure: dest_tready toggling 1,0,0,1,... -> dest_tdata and dest_tlast stable during stalls; no element lost or duplicated (scoreboard check).
- Reset mid-word: rst held 1 cycle after 2 of 4 elements -> dest_tvalid=0 during rst; next word 0x88776655 emits 0x55 first.
- TKEEP (macro defined):
  - keep=4'b0101, data 0xDDCCBBAA, tlast=1 -> emits 0xAA then 0xCC, dest_tlast on 0xCC.
  - keep=4'b0000 with tlast=1 -> no beats; null_last_err pulses once.

Source files
------------

// File: rtl/axistream_pkg.sv
// Shared AXI-Stream pack/unpack definitions: endianness constants and index-width helper.
package axistream_pkg;

    localparam bit AXIS_LITTLE = 1'b0;
    localparam bit AXIS_BIG    = 1'b1;

    // Index width for n elements, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/axistream_unpack_if.sv
// Wide-in / narrow-out stream bundle for axistream_unpack.
// src_tkeep exists only when AXISTREAM_UNPACK_TKEEP_EN is defined.
interface axistream_unpack_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PACK   = 4
);
    logic                           src_tvalid;
    logic                           src_tready;
    logic [DATA_WIDTH*NUM_PACK-1:0] src_tdata;
    logic                           src_tlast;
`ifdef AXISTREAM_UNPACK_TKEEP_EN
    logic [NUM_PACK-1:0]            src_tkeep;
`endif
    logic                           dest_tvalid;
    logic                           dest_tready;
    logic [DATA_WIDTH-1:0]          dest_tdata;
    logic                           dest_tlast;

`ifdef AXISTREAM_UNPACK_TKEEP_EN
    modport slave (
        input  src_tvalid, src_tdata, src_tlast, src_tkeep, dest_tready,
        output src_tready, dest_tvalid, dest_tdata, dest_tlast
    );
    modport master (
        output src_tvalid, src_tdata, src_tlast, src_tkeep, dest_tready,
        input  src_tready, dest_tvalid, dest_tdata, dest_tlast
    );
`else
    modport slave (
        input  src_tvalid, src_tdata, src_tlast, dest_tready,
        output src_tready, dest_tvalid, dest_tdata, dest_tlast
    );
    modport master (
        output src_tvalid, src_tdata, src_tlast, dest_tready,
        input  src_tready, dest_tvalid, dest_tdata, dest_tlast
    );
`endif

endinterface

// File: rtl/axistream_unpack_sel.sv
// Element mux plus priority encoders for the next kept element (idx is an emission-order position).
module axistream_unpack_sel
    import axistream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PACK   = 4,
    parameter bit          BIG_ENDIAN = AXIS_LITTLE,
    localparam int unsigned IW        = idx_width(NUM_PACK),
    localparam int unsigned WW        = DATA_WIDTH * NUM_PACK
) (
    input  logic [WW-1:0]         data,
    input  logic [NUM_PACK-1:0]   keep,
    input  logic [IW-1:0]         idx,
    input  logic [NUM_PACK-1:0]   keep_in,
    output logic [DATA_WIDTH-1:0] elem_c,
    output logic                  is_final_c,
    output logic [IW-1:0]         next_idx_c,
    output logic [IW-1:0]         first_idx_c,
    output logic                  any_in_c
);

    logic [NUM_PACK-1:0] keep_e;
    logic [NUM_PACK-1:0] keep_in_e;
    int unsigned         phys;

    always_comb begin
        keep_e      = '0;
        keep_in_e   = '0;
        is_final_c  = 1'b1;
        next_idx_c  = '0;
        first_idx_c = '0;
        any_in_c    = 1'b0;

        // Reorder keep masks so bit p is the p-th element in emission order.
        for (int p = 0; p < int'(NUM_PACK); p++) begin
            keep_e[p]    = BIG_ENDIAN ? keep[int'(NUM_PACK) - 1 - p]    : keep[p];
            keep_in_e[p] = BIG_ENDIAN ? keep_in[int'(NUM_PACK) - 1 - p] : keep_in[p];
        end

        phys   = BIG_ENDIAN ? (NUM_PACK - 32'd1 - 32'(idx)) : 32'(idx);
        elem_c = data[phys*DATA_WIDTH +: DATA_WIDTH];

        // Descending scan so the lowest qualifying position wins.
        for (int p = int'(NUM_PACK) - 1; p >= 0; p--) begin
            if (keep_e[p] && (p > int'(idx))) begin
                is_final_c = 1'b0;
                next_idx_c = IW'(p);
            end
            if (keep_in_e[p]) begin
                any_in_c    = 1'b1;
                first_idx_c = IW'(p);
            end
        end
    end

endmodule

// File: rtl/axistream_unpack.sv
// Splits each wide stream word into NUM_PACK narrow elements, one per beat, with zero-bubble reload.
// Optional AXISTREAM_UNPACK_TKEEP_EN adds src_tkeep element skipping and null_last_err.
module axistream_unpack
    import axistream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PACK   = 4,
    parameter bit          BIG_ENDIAN = AXIS_LITTLE
) (
    input  logic               clk,
    input  logic               rst,
    axistream_unpack_if.slave  bus
`ifdef AXISTREAM_UNPACK_TKEEP_EN
    ,
    output logic               null_last_err
`endif
);

    localparam int unsigned IW = idx_width(NUM_PACK);
    localparam int unsigned WW = DATA_WIDTH * NUM_PACK;

    logic [WW-1:0]         data_buf;
    logic                  last_buf;
    logic [NUM_PACK-1:0]   keep_buf;
    logic [NUM_PACK-1:0]   keep_in;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_d;
    logic                  full;
    logic                  full_d;
    logic                  err_q;
    logic                  err_d;

    logic [DATA_WIDTH-1:0] elem;
    logic                  is_final;
    logic [IW-1:0]         next_idx;
    logic [IW-1:0]         first_idx;
    logic                  any_in;
    logic                  src_hs;
    logic                  dest_hs;

`ifdef AXISTREAM_UNPACK_TKEEP_EN
    assign keep_in       = bus.src_tkeep;
    assign null_last_err = err_q && !rst;

    always_ff @(posedge clk) begin
        if (src_hs) begin
            keep_buf <= keep_in;
        end
    end
`else
    assign keep_in  = '1;
    assign keep_buf = '1;
`endif

    axistream_unpack_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PACK   (NUM_PACK),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_sel (
        .data        (data_buf),
        .keep        (keep_buf),
        .idx         (idx),
        .keep_in     (keep_in),
        .elem_c      (elem),
        .is_final_c  (is_final),
        .next_idx_c  (next_idx),
        .first_idx_c (first_idx),
        .any_in_c    (any_in)
    );

    assign bus.src_tready  = !rst && (!full || (bus.dest_tready && is_final));
    assign bus.dest_tvalid = full && !rst;
    assign bus.dest_tdata  = elem;
    assign bus.dest_tlast  = !rst && full && last_buf && is_final;

    assign src_hs  = bus.src_tvalid && bus.src_tready;
    assign dest_hs = bus.dest_tvalid && bus.dest_tready;

    // A source handshake while full can only coincide with the final element leaving.
    always_comb begin
        full_d = full;
        idx_d  = idx;
        err_d  = 1'b0;
        if (src_hs) begin
            full_d = any_in;
            idx_d  = first_idx;
            err_d  = !any_in && bus.src_tlast;
        end else if (dest_hs) begin
            if (is_final) begin
                full_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d  = next_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            idx   <= '0;
            err_q <= 1'b0;
        end else begin
            full  <= full_d;
            idx   <= idx_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (src_hs) begin
            data_buf <= bus.src_tdata;
            last_buf <= bus.src_tlast;
        end
    end

endmodule

// File: tb/tb_axistream_unpack.sv
// Randomized scoreboard bench for axistream_unpack: little- and big-endian instances share one stimulus.
module tb_axistream_unpack;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } elem_t;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [3:0]  k;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axistream_unpack_if #(.DATA_WIDTH(8), .NUM_PACK(4)) le_if ();
    axistream_unpack_if #(.DATA_WIDTH(8), .NUM_PACK(4)) be_if ();

`ifdef AXISTREAM_UNPACK_TKEEP_EN
    logic le_err;
    logic be_err;
`endif

    axistream_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b0)) u_le (
        .clk (clk),
        .rst (rst),
        .bus (le_if.slave)
`ifdef AXISTREAM_UNPACK_TKEEP_EN
        ,
        .null_last_err (le_err)
`endif
    );

    axistream_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b1)) u_be (
        .clk (clk),
        .rst (rst),
        .bus (be_if.slave)
`ifdef AXISTREAM_UNPACK_TKEEP_EN
        ,
        .null_last_err (be_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    elem_t       le_q[$];
    elem_t       be_q[$];
    word_t       src_q[$];
    bit          src_pending = 1'b0;
    bit          src_acc     = 1'b0;
    int          rdy_mode    = 0;
    int unsigned gap_pct     = 0;
    int          cyc         = 0;
    int          hs_cnt      = 0;
    int          run_len     = 0;
    int          max_run     = 0;
    logic [7:0]  le_tl_data  = '0;
    logic [7:0]  be_tl_data  = '0;
    bit          want_first  = 1'b0;
    logic [7:0]  first_data  = '0;
    bit          err_exp     = 1'b0;
    int          err_cnt     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected element sequence of one word: plain byte arithmetic, kept elements only.
    function automatic void push_word(input word_t w, input bit big);
        int    n_kept;
        int    cnt;
        int    phys;
        elem_t e;
        n_kept = 0;
        cnt    = 0;
        for (int i = 0; i < 4; i++) n_kept += int'(w.k[i]);
        for (int k = 0; k < 4; k++) begin
            phys = big ? 3 - k : k;
            if (w.k[phys]) begin
                cnt++;
                e.d = 8'(w.d >> (8 * phys));
                e.l = w.l && (cnt == n_kept);
                if (big) be_q.push_back(e);
                else     le_q.push_back(e);
            end
        end
    endfunction

    always @(negedge clk) begin
        word_t w;
        bit    exp_rdy;
        if (rst) begin
            check_eq("rst_le_valid", 32'(le_if.dest_tvalid), 32'd0);
            check_eq("rst_le_ready", 32'(le_if.src_tready), 32'd0);
            check_eq("rst_le_tlast", 32'(le_if.dest_tlast), 32'd0);
            check_eq("rst_be_valid", 32'(be_if.dest_tvalid), 32'd0);
`ifdef AXISTREAM_UNPACK_TKEEP_EN
            check_eq("rst_err", 32'(le_err), 32'd0);
`endif
            le_q.delete();
            be_q.delete();
            src_acc    = 1'b0;
            err_exp    = 1'b0;
            run_len    = 0;
            want_first = 1'b1;
        end else begin
            check_eq("le_valid", 32'(le_if.dest_tvalid), 32'(le_q.size() != 0));
            check_eq("be_valid", 32'(be_if.dest_tvalid), 32'(be_q.size() != 0));
            exp_rdy = (le_q.size() == 0) || (le_if.dest_tready && le_q.size() == 1);
            check_eq("le_src_ready", 32'(le_if.src_tready), 32'(exp_rdy));
            check_eq("be_src_ready", 32'(be_if.src_tready), 32'(exp_rdy));
`ifdef AXISTREAM_UNPACK_TKEEP_EN
            check_eq("null_last_err", 32'(le_err), 32'(err_exp));
            check_eq("be_null_last_err", 32'(be_err), 32'(err_exp));
            if (le_err) err_cnt++;
`endif
            err_exp = 1'b0;
            if (le_if.dest_tvalid && le_q.size() > 0) begin
                check_eq("le_data", 32'(le_if.dest_tdata), 32'(le_q[0].d));
                check_eq("le_tlast", 32'(le_if.dest_tlast), 32'(le_q[0].l));
            end
            if (be_if.dest_tvalid && be_q.size() > 0) begin
                check_eq("be_data", 32'(be_if.dest_tdata), 32'(be_q[0].d));
                check_eq("be_tlast", 32'(be_if.dest_tlast), 32'(be_q[0].l));
            end
            if (le_if.dest_tvalid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (le_if.dest_tvalid && le_if.dest_tready) begin
                hs_cnt++;
                if (le_if.dest_tlast) le_tl_data = le_if.dest_tdata;
                if (want_first) begin
                    first_data = le_if.dest_tdata;
                    want_first = 1'b0;
                end
                if (le_q.size() > 0) void'(le_q.pop_front());
            end
            if (be_if.dest_tvalid && be_if.dest_tready) begin
                if (be_if.dest_tlast) be_tl_data = be_if.dest_tdata;
                if (be_q.size() > 0) void'(be_q.pop_front());
            end
            src_acc = le_if.src_tvalid && le_if.src_tready;
            if (src_acc) begin
                w.d = le_if.src_tdata;
                w.l = le_if.src_tlast;
`ifdef AXISTREAM_UNPACK_TKEEP_EN
                w.k = le_if.src_tkeep;
`else
                w.k = 4'hF;
`endif
                push_word(w, 1'b0);
                push_word(w, 1'b1);
                err_exp = (w.k == 4'h0) && w.l;
            end
        end
    end

    task automatic drive_src(input word_t w);
        le_if.src_tdata = w.d;
        be_if.src_tdata = w.d;
        le_if.src_tlast = w.l;
        be_if.src_tlast = w.l;
`ifdef AXISTREAM_UNPACK_TKEEP_EN
        le_if.src_tkeep = w.k;
        be_if.src_tkeep = w.k;
`endif
    endtask

    task automatic cycle();
        bit rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (src_acc) src_pending = 1'b0;
        if (!src_pending && src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            drive_src(src_q.pop_front());
            src_pending = 1'b1;
        end
        le_if.src_tvalid = src_pending;
        be_if.src_tvalid = src_pending;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(1));
        endcase
        le_if.dest_tready = rdy;
        be_if.dest_tready = rdy;
    endtask

    task automatic run_until_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (src_q.size() == 0 && !src_pending && le_q.size() == 0 && be_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("drain_timeout", 32'(done), 32'd1);
        repeat (2) cycle();
    endtask

    task automatic enq(input logic [31:0] d, input logic l, input logic [3:0] k);
        word_t w;
        w.d = d;
        w.l = l;
        w.k = k;
        src_q.push_back(w);
    endtask

    initial begin
        int start;
        bit got2;
        le_if.src_tvalid  = 1'b0;
        be_if.src_tvalid  = 1'b0;
        le_if.src_tdata   = '0;
        be_if.src_tdata   = '0;
        le_if.src_tlast   = 1'b0;
        be_if.src_tlast   = 1'b0;
        le_if.dest_tready = 1'b0;
        be_if.dest_tready = 1'b0;
`ifdef AXISTREAM_UNPACK_TKEEP_EN
        le_if.src_tkeep   = '0;
        be_if.src_tkeep   = '0;
`endif
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;

        // Ordering: one word, both endiannesses
        rdy_mode = 0;
        gap_pct  = 0;
        enq(32'h44332211, 1'b1, 4'hF);
        run_until_idle(50);
        check_eq("le_tlast_elem", 32'(le_tl_data), 32'h44);
        check_eq("be_tlast_elem", 32'(be_tl_data), 32'h11);

        // Back-to-back words with both sides ready
        max_run = 0;
        enq(32'hDDCCBBAA, 1'b0, 4'hF);
        enq(32'h04030201, 1'b1, 4'hF);
        run_until_idle(50);
        check_eq("b2b_run", 32'(max_run), 32'd8);

        // Backpressure pattern 1,0,0
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) enq($urandom, 1'($urandom_range(1)), 4'hF);
        run_until_idle(200);

        // Reset after two elements of a word
        rdy_mode = 0;
        enq(32'hCAFEF00D, 1'b1, 4'hF);
        start = hs_cnt;
        got2  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (hs_cnt - start >= 2) begin
                got2 = 1'b1;
                break;
            end
        end
        check_eq("midword_wait", 32'(got2), 32'd1);
        rst = 1'b1;
        src_q.delete();
        src_pending      = 1'b0;
        le_if.src_tvalid = 1'b0;
        be_if.src_tvalid = 1'b0;
        cycle();
        rst = 1'b0;
        enq(32'h88776655, 1'b1, 4'hF);
        run_until_idle(50);
        check_eq("first_after_rst", 32'(first_data), 32'h55);

        // Random traffic
        rdy_mode = 2;
        gap_pct  = 30;
        for (int i = 0; i < 150; i++) begin
`ifdef AXISTREAM_UNPACK_TKEEP_EN
            enq($urandom, 1'($urandom_range(1)),
                ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom));
`else
            enq($urandom, 1'($urandom_range(1)), 4'hF);
`endif
        end
        run_until_idle(3000);

`ifdef AXISTREAM_UNPACK_TKEEP_EN
        // Sparse keep and all-zero keep
        rdy_mode = 0;
        gap_pct  = 0;
        enq(32'hDDCCBBAA, 1'b1, 4'b0101);
        run_until_idle(50);
        check_eq("keep_le_tlast", 32'(le_tl_data), 32'hCC);
        check_eq("keep_be_tlast", 32'(be_tl_data), 32'hAA);
        err_cnt = 0;
        enq(32'h12345678, 1'b1, 4'b0000);
        run_until_idle(50);
        check_eq("null_err_pulses", 32'(err_cnt), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
